pic_bus_buffer_sync: RTL
========================

// Module: pic_bus_buffer_sync
// PURPOSE
//  Clocked, parametrised data-bus buffer between the external CPU bus and the PIC internal bus.
//  Captures CPU writes into a write FIFO drained by the internal side (valid/ready).
//  Presents held read or cascade data with a controlled output enable and bus turnaround.
//  Flags RD/WR conflicts and write overflow. Sits between the CPU pins and the control logic.
// PARAMETERS
//  DATA_W      8  bus width, both sides
//  WFIFO_DEPTH 4  write FIFO entries; power of two, >=2
//  TURNAROUND  1  idle cycles with oe low after a read/cascade drive; 0..15
// PORTS
//  clk        in   1       single clock, all state rising-edge
//  reset      in   1       asynchronous, active-high
//  rd_n       in   1       CPU read strobe, active low, synchronous to clk
//  wr_n       in   1       CPU write strobe, active low, synchronous to clk
//  data_in    in   DATA_W  external bus sampled value
//  data_out   out  DATA_W  value driven onto external bus when data_oe=1
//  data_oe    out  1       external bus drive enable (pad tri-state control)
//  cas_drive  in   1       cascade logic requests bus drive (vector output)
//  cas_data   in   DATA_W  cascade vector to drive
//  int_rdata  in   DATA_W  internal read data (status/IRR/ISR/IMR selected upstream)
//  int_wdata  out  DATA_W  FIFO head (show-ahead)
//  int_wvalid out  1       FIFO non-empty
//  int_wready in   1       internal side pops head when int_wvalid & int_wready
//  wcount     out  $clog2(WFIFO_DEPTH)+1  FIFO occupancy
//  ovf        out  1       sticky: write dropped because FIFO full
//  ovf_clr    in   1       clears ovf (set has priority in the same cycle)
//  bus_err    out  1       one-cycle pulse: rd_n and wr_n both low while in IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, data_oe=0, data_out=0, FIFO empty, wcount=0,
//   int_wvalid=0, int_wdata=0, ovf=0, bus_err=0, turnaround counter=0.
//  All outputs are registered; decisions use rd_n/wr_n/cas_drive as sampled at the edge.
//  FSM states: IDLE, READ, WRITE, CAS, TURN. Entry priority from IDLE: cas_drive > read > write.
//  IDLE: data_oe=0.
//   cas_drive=1                 -> CAS; data_out<=cas_data.
//   rd_n=0 & wr_n=1             -> READ; data_out<=int_rdata.
//   wr_n=0 & rd_n=1             -> WRITE; wlatch<=data_in.
//   rd_n=0 & wr_n=0, no cas     -> stay IDLE; bus_err<=1 for one cycle.
//  READ: data_oe=1 from the cycle after entry (1-cycle latency rd_n-low to oe).
//   data_out is held, not re-sampled. On rd_n=1 -> TURN, or -> IDLE if TURNAROUND=0.
//   data_oe falls on the same edge.
//  CAS: same as READ but held by cas_drive; exits on cas_drive=0. rd_n/wr_n are ignored.
//  WRITE: while wr_n=0, wlatch<=data_in every cycle, so the last value before release wins.
//   On wr_n=1: push wlatch, -> IDLE.
//   rd_n falling during WRITE is ignored until IDLE.
//  TURN: data_oe=0; counter loads TURNAROUND-1 on entry; -> IDLE when it reaches 0.
//   Strobes are ignored in TURN.
//  FIFO push/pop:
//   Push when full without a same-cycle pop: data dropped, ovf<=1.
//   Push when full with a same-cycle pop: accepted; wcount unchanged.
//   Push and pop together when not full/empty: wcount unchanged, order preserved.
//   Pop when empty: no effect.
//   Pointers wrap modulo WFIFO_DEPTH, with an extra MSB for full/empty.
//  wcount, int_wvalid and int_wdata update on the edge after the push/pop.
//   A push-to-visible latency is 1 cycle after the wr_n release edge.
//  ovf_clr with a simultaneous overflow: ovf stays 1.
//  Reset asserted mid-READ/CAS: data_oe drops asynchronously. Mid-WRITE: the latched byte is discarded.
// TESTING
//  1 Write 0xA5 (wr_n low 3 cycles, data 0x11,0x22,0xA5) -> one FIFO entry 0xA5, wcount=1, int_wvalid=1.
//  2 int_wready=0, 5 writes into DEPTH=4 -> wcount=4, ovf=1, head=first byte.
//    Then ovf_clr -> ovf=0.
//  3 Full FIFO, 5th write release coinciding with a pop -> accepted, wcount=4, ovf=0, order intact.
//  4 int_rdata=0x3C, rd_n low 4 cycles -> data_oe=1 cycles 2..5, data_out=0x3C throughout.
//    data_oe=0 for TURNAROUND=1 cycle, then a new read is accepted.
//  5 rd_n=0 & wr_n=0 in IDLE -> bus_err single pulse, data_oe=0, no push.
//    cas_drive=1 with rd_n=0 -> data_out=cas_data.
//  6 reset pulse during READ (oe=1) and during WRITE -> data_oe=0 immediately, wcount=0, ovf=0, state IDLE.

Source files
------------

// File: rtl/pic_bus_buffer_sync.sv
// rtl/pic_bus_buffer_sync.sv - CPU/internal data-bus buffer with write FIFO and drive turnaround
// All outputs come straight from flops; strobes are acted on as sampled at the rising edge.
module pic_bus_buffer_sync #(
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4,
    parameter int TURNAROUND  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_oe,
    input  logic                         cas_drive,
    input  logic [DATA_W-1:0]            cas_data,
    input  logic [DATA_W-1:0]            int_rdata,
    output logic [DATA_W-1:0]            int_wdata,
    output logic                         int_wvalid,
    input  logic                         int_wready,
    output logic [$clog2(WFIFO_DEPTH):0] wcount,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic                         bus_err
);

    localparam int AW = $clog2(WFIFO_DEPTH);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CAS   = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [AW:0] FULL_CNT = WFIFO_DEPTH[AW:0];

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic [DATA_W-1:0] wlatch_q, wlatch_d;
    logic [3:0]        turn_cnt_q, turn_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] mem_q [WFIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [WFIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       wcount_q, wcount_d;
    logic              int_wvalid_q, int_wvalid_d;
    logic [DATA_W-1:0] int_wdata_q, int_wdata_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, push_ok, full, drive_end;

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        wlatch_d   = wlatch_q;
        turn_cnt_d = turn_cnt_q;
        bus_err_d  = 1'b0;
        push       = 1'b0;
        drive_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cas_drive) begin
                    state_d    = S_CAS;
                    data_out_d = cas_data;
                    data_oe_d  = 1'b1;
                end else if (!rd_n && wr_n) begin
                    state_d    = S_READ;
                    data_out_d = int_rdata;
                    data_oe_d  = 1'b1;
                end else if (!wr_n && rd_n) begin
                    state_d  = S_WRITE;
                    wlatch_d = data_in;
                end else if (!rd_n && !wr_n) begin
                    bus_err_d = 1'b1;
                end
            end
            S_READ:  drive_end = rd_n;
            S_CAS:   drive_end = !cas_drive;
            S_WRITE: begin
                if (wr_n) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wlatch_d = data_in;
                end
            end
            S_TURN: begin
                if (turn_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
            end
        endcase
        // Releasing the bus always passes through the turnaround gap unless it is zero length.
        if (drive_end) begin
            data_oe_d = 1'b0;
            if (TURNAROUND == 0) begin
                state_d = S_IDLE;
            end else begin
                state_d    = S_TURN;
                turn_cnt_d = TURN_LOAD;
            end
        end
    end

    always_comb begin
        full    = (wcount_q == FULL_CNT);
        pop     = int_wvalid_q && int_wready;
        push_ok = push && (!full || pop);
        ovf_d   = (push && full && !pop) || (ovf_q && !ovf_clr);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = wlatch_q;
        end
        wcount_d     = wr_ptr_d - rd_ptr_d;
        int_wvalid_d = (wcount_d != '0);
        // Show-ahead head is taken from the post-write array so a push into an empty FIFO is seen at once.
        int_wdata_d  = int_wvalid_d ? mem_d[rd_ptr_d[AW-1:0]] : int_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            wlatch_q     <= '0;
            turn_cnt_q   <= 4'd0;
            bus_err_q    <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wcount_q     <= '0;
            int_wvalid_q <= 1'b0;
            int_wdata_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            wlatch_q     <= wlatch_d;
            turn_cnt_q   <= turn_cnt_d;
            bus_err_q    <= bus_err_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wcount_q     <= wcount_d;
            int_wvalid_q <= int_wvalid_d;
            int_wdata_q  <= int_wdata_d;
            ovf_q        <= ovf_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign int_wdata  = int_wdata_q;
    assign int_wvalid = int_wvalid_q;
    assign wcount     = wcount_q;
    assign ovf        = ovf_q;
    assign bus_err    = bus_err_q;

endmodule
